dcache_s2_nway: RTL and testbench
=================================

# dcache_s2_nway

Parametrised second stage of the data cache. Resolves hit/miss across `WAYS` ways for the request latched by stage 1 and runs the miss engine: dirty-victim write-back, line refill, and uncached single-word read/write. It also produces the refill/install and hit-write controls returned to stage 1 and the load data returned to the CPU. Compared with the previous 2-way stage it generalises way count and line length, merges write-miss data into the refilled line, and holds load data until the CPU acknowledges it.

## Interface
- `WAYS`, 2, number of ways (power of two, 2..8)
- `LINE_WORDS`, 8, 32-bit words per line (power of two, 4..16)
- `INDEX_W`, 7, set-index bits; `TAG_W` = 32 − `INDEX_W` − log2(`LINE_WORDS`·4)
- `clk` in 1 clock
- `rst_n` in 1 asynchronous, active-low reset
- `req_valid_i` in 1 stage-1 request present this cycle
- `req_wr_i` in 1 1 = store, 0 = load
- `req_uc_i` in 1 uncached access
- `req_addr_i` in 32 physical address
- `req_wstrb_i` in 4 byte enables for stores
- `req_wdata_i` in 32 store data
- `tag_i` in `WAYS`·`TAG_W` per-way tag, way 0 in the LSBs
- `valid_i`, `dirty_i` in `WAYS` per-way valid/dirty
- `data_i` in `WAYS`·32 per-way word at the addressed bank (collision-forwarded by stage 1)
- `victim_i` in log2(`WAYS`) replacement way from the LRU
- `victim_line_i` in `LINE_WORDS`·32 victim line data for write-back
- `mem_rreq_o`, `mem_wreq_o` out 1 one-cycle request pulses to the AXI bridge
- `mem_uc_o` out 1 request is an uncached single word
- `mem_addr_o` out 32 request address
- `mem_wline_o` out `LINE_WORDS`·32 write data (word 0 only used when uncached)
- `mem_wstrb_o` out 4 uncached write strobes
- `mem_rend_i`, `mem_wend_i` in 1 read/write completion pulses
- `mem_rline_i` in `LINE_WORDS`·32 read data, valid with `mem_rend_i`
- `stall_o` out 1 freeze stages 0–1
- `hit_o` out 1; `hit_way_o` out log2(`WAYS`)
- `hit_we_o` out 1; `hit_wdata_o` out 32 byte-merged store word for a store hit
- `fill_we_o` out 1; `fill_way_o` out log2(`WAYS`); `fill_line_o` out `LINE_WORDS`·32; `fill_dirty_o` out 1
- `cpu_rdata_o` out 32; `cpu_rvalid_o` out 1; `cpu_ack_i` in 1

## Operation
- Address split: tag = `[31 -: TAG_W]`, index follows, word select = `addr[2 +: log2(LINE_WORDS)]`.
- Hit for way w: `valid_i[w]` && tag match. If several ways hit, the lowest index wins. `hit_o` is only meaningful in IDLE with `req_valid_i` and !`req_uc_i`.
- FSM states: IDLE, WB, RF, UC_RD, UC_WR, FILL.
- In IDLE with a valid request:
  - Cached hit: load → `cpu_rvalid_o`; store → `hit_we_o`, with `hit_wdata_o` = bytes from `req_wdata_i` where the strobe is set, else from the hit way's data. State stays IDLE.
  - Cached miss, victim dirty and valid → WB.
  - Cached miss, otherwise → RF.
  - Uncached load → UC_RD; uncached store → UC_WR.
- WB: pulse `mem_wreq_o` with `mem_addr_o` = {victim tag, index, 0}, `mem_wline_o` = `victim_line_i`. On `mem_wend_i` → RF.
- RF: pulse `mem_rreq_o` with `mem_addr_o` = line-aligned request address. On `mem_rend_i`, latch the line, merging the store word with strobes for a write miss → FILL.
- FILL, exactly one cycle:
  - `fill_we_o` = 1, `fill_way_o` = latched victim, `fill_dirty_o` = `req_wr_i`.
  - Load: capture the word into the read buffer.
  - → IDLE.
- UC_RD: pulse request with `mem_uc_o` = 1 and the full address. On `mem_rend_i`, capture word 0 → IDLE.
- UC_WR: pulse write with word 0 = `req_wdata_i` and `mem_wstrb_o` = `req_wstrb_i`. On `mem_wend_i` → IDLE.
- Read buffer: `cpu_rvalid_o` is held with `cpu_rdata_o` until `cpu_ack_i`. A new load hit while the buffer is unacked stalls.
- The request, victim, and merged line are registered on leaving IDLE. Stage-1 inputs are ignored until return to IDLE.

## Timing
- Reset values: all outputs 0; FSM in IDLE; read buffer empty.
- `stall_o` is combinational:
  - 1 in IDLE on a miss or uncached request.
  - 1 in every non-IDLE state, including FILL.
  - 0 in the cycle the FSM is back in IDLE.
- Request pulses are asserted exactly one cycle, the first cycle in WB/RF/UC_*, and never re-issued while waiting.
- Hit load latency: `cpu_rvalid_o` in the same cycle. Miss load latency: `cpu_rvalid_o` one cycle after `mem_rend_i`.
- A `mem_rend_i`/`mem_wend_i` that does not match the current state is ignored.
- Reset asserted mid-miss: immediate return to IDLE, no fill, no pulse; bridge cleanup is the bridge's job.
- `cpu_ack_i` and new data in the same cycle: the buffer loads the new data and stays valid.

## Test plan
- 2-way, load hit in way 1 (tag match, valid) → `hit_o` = 1, `hit_way_o` = 1, `cpu_rdata_o` = `data_i[63:32]` same cycle, `stall_o` = 0.
- Store hit, strobe 4'b0101, old 0xAABBCCDD, new 0x11223344 → `hit_wdata_o` = 0xAA22CC44, `hit_we_o` = 1.
- Clean load miss at 0x0000_1024 → `mem_rreq_o` single pulse at 0x0000_1020; after `mem_rend_i`, one FILL cycle then `cpu_rdata_o` = word 1 of the line.
- Dirty store miss, `WAYS` = 4, `victim_i` = 2:
  - `mem_wreq_o` at the victim address.
  - After `mem_wend_i`, `mem_rreq_o`.
  - FILL with `fill_way_o` = 2, `fill_dirty_o` = 1, and the merged word present.
- Uncached store, strobe 4'b1000 → `mem_wreq_o`, `mem_uc_o` = 1, `mem_wstrb_o` = 4'b1000. A spurious `mem_rend_i` is ignored; IDLE after `mem_wend_i`.
- Reset pulse during RF → all outputs 0, IDLE; a subsequent hit is served normally.

Source files
------------

// File: rtl/dcache_s2_nway.sv
// dcache_s2_nway: data cache stage 2 with N-way hit resolution, miss engine and CPU read buffer
module dcache_s2_nway #(
  parameter int WAYS = 2,
  parameter int LINE_WORDS = 8,
  parameter int INDEX_W = 7,
  localparam int WW = $clog2(WAYS),
  localparam int LW = $clog2(LINE_WORDS),
  localparam int OFF = LW + 2,
  localparam int TAG_W = 32 - INDEX_W - OFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  input  logic                       req_wr_i,
  input  logic                       req_uc_i,
  input  logic [31:0]                req_addr_i,
  input  logic [3:0]                 req_wstrb_i,
  input  logic [31:0]                req_wdata_i,
  input  logic [WAYS*TAG_W-1:0]      tag_i,
  input  logic [WAYS-1:0]            valid_i,
  input  logic [WAYS-1:0]            dirty_i,
  input  logic [WAYS*32-1:0]         data_i,
  input  logic [WW-1:0]              victim_i,
  input  logic [LINE_WORDS*32-1:0]   victim_line_i,
  output logic                       mem_rreq_o,
  output logic                       mem_wreq_o,
  output logic                       mem_uc_o,
  output logic [31:0]                mem_addr_o,
  output logic [LINE_WORDS*32-1:0]   mem_wline_o,
  output logic [3:0]                 mem_wstrb_o,
  input  logic                       mem_rend_i,
  input  logic                       mem_wend_i,
  input  logic [LINE_WORDS*32-1:0]   mem_rline_i,
  output logic                       stall_o,
  output logic                       hit_o,
  output logic [WW-1:0]              hit_way_o,
  output logic                       hit_we_o,
  output logic [31:0]                hit_wdata_o,
  output logic                       fill_we_o,
  output logic [WW-1:0]              fill_way_o,
  output logic [LINE_WORDS*32-1:0]   fill_line_o,
  output logic                       fill_dirty_o,
  output logic [31:0]                cpu_rdata_o,
  output logic                       cpu_rvalid_o,
  input  logic                       cpu_ack_i
);
  typedef enum logic [2:0] {IDLE, WB, RF, UC_RD, UC_WR, FILL} state_t;
  state_t state_q, state_d;
  logic pend_q, pend_d, wr_q, wr_d, rvalid_q, rvalid_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [WW-1:0] victim_q, victim_d;
  logic [TAG_W-1:0] vtag_q, vtag_d;
  logic [LINE_WORDS*32-1:0] line_q, line_d;
  logic any_hit, vdirty, idle, ld_blk, ld_hit;
  logic [WW-1:0] hit_way;
  logic [31:0] hit_word, rf_word;
  logic [TAG_W-1:0] vtag;
  logic [LINE_WORDS*32-1:0] rf_line;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) merge[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
  endfunction

  // way lookup: lowest matching way wins; victim tag/dirty selection
  always_comb begin
    any_hit = 1'b0;
    hit_way = '0;
    hit_word = '0;
    vtag = '0;
    vdirty = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_i[w] && tag_i[w*TAG_W +: TAG_W] == req_addr_i[31 -: TAG_W]) begin
        any_hit = 1'b1;
        hit_way = WW'(w);
        hit_word = data_i[w*32 +: 32];
      end
      if (victim_i == WW'(w)) begin
        vtag = tag_i[w*TAG_W +: TAG_W];
        vdirty = valid_i[w] && dirty_i[w];
      end
    end
  end

  // refill line with the pending store word merged in, plus the requested word
  always_comb begin
    rf_line = mem_rline_i;
    rf_word = '0;
    for (int k = 0; k < LINE_WORDS; k++)
      if (addr_q[2 +: LW] == LW'(k)) begin
        rf_word = mem_rline_i[k*32 +: 32];
        if (wr_q) rf_line[k*32 +: 32] = merge(mem_rline_i[k*32 +: 32], wdata_q, wstrb_q);
      end
  end

  assign idle = state_q == IDLE;
  assign hit_o = idle && req_valid_i && !req_uc_i && any_hit;
  assign hit_way_o = hit_o ? hit_way : '0;
  assign hit_we_o = hit_o && req_wr_i;
  assign hit_wdata_o = hit_we_o ? merge(hit_word, req_wdata_i, req_wstrb_i) : '0;
  assign ld_blk = !req_wr_i && rvalid_q;
  assign ld_hit = hit_o && !ld_blk && !req_wr_i;
  assign stall_o = !idle || (req_valid_i && (req_uc_i || !any_hit || ld_blk));
  assign cpu_rvalid_o = rvalid_q || ld_hit;
  assign cpu_rdata_o = rvalid_q ? rbuf_q : ld_hit ? hit_word : '0;
  assign mem_rreq_o = pend_q && (state_q == RF || state_q == UC_RD);
  assign mem_wreq_o = pend_q && (state_q == WB || state_q == UC_WR);
  assign mem_uc_o = state_q == UC_RD || state_q == UC_WR;
  assign mem_addr_o = state_q == WB ? {vtag_q, addr_q[OFF +: INDEX_W], OFF'(0)} :
                      state_q == RF ? {addr_q[31:OFF], OFF'(0)} : mem_uc_o ? addr_q : '0;
  assign mem_wline_o = state_q == WB ? line_q : state_q == UC_WR ? {{(LINE_WORDS-1)*32{1'b0}}, wdata_q} : '0;
  assign mem_wstrb_o = state_q == UC_WR ? wstrb_q : '0;
  assign fill_we_o = state_q == FILL;
  assign fill_way_o = fill_we_o ? victim_q : '0;
  assign fill_line_o = fill_we_o ? line_q : '0;
  assign fill_dirty_o = fill_we_o && wr_q;

  // miss engine next state, request capture and read buffer update
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    victim_d = victim_q;
    vtag_d = vtag_q;
    line_d = line_q;
    rbuf_d = rbuf_q;
    rvalid_d = rvalid_q && !cpu_ack_i;
    case (state_q)
      IDLE: begin
        if (ld_hit && !cpu_ack_i) begin
          rbuf_d = hit_word;
          rvalid_d = 1'b1;
        end
        if (req_valid_i && (req_uc_i || !any_hit) && !ld_blk) begin
          wr_d = req_wr_i;
          addr_d = req_addr_i;
          wstrb_d = req_wstrb_i;
          wdata_d = req_wdata_i;
          victim_d = victim_i;
          vtag_d = vtag;
          line_d = victim_line_i;
          state_d = req_uc_i ? (req_wr_i ? UC_WR : UC_RD) : vdirty ? WB : RF;
        end
      end
      WB: state_d = mem_wend_i ? RF : WB;
      RF: if (mem_rend_i) begin
        line_d = rf_line;
        state_d = FILL;
        if (!wr_q) begin
          rbuf_d = rf_word;
          rvalid_d = 1'b1;
        end
      end
      UC_RD: if (mem_rend_i) begin
        rbuf_d = mem_rline_i[31:0];
        rvalid_d = 1'b1;
        state_d = IDLE;
      end
      UC_WR: state_d = mem_wend_i ? IDLE : UC_WR;
      default: state_d = IDLE;
    endcase
    pend_d = state_d != state_q && state_d inside {WB, RF, UC_RD, UC_WR};
  end

  // state and request registers; reset abandons any miss in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      victim_q <= '0;
      vtag_q <= '0;
      line_q <= '0;
      rbuf_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      victim_q <= victim_d;
      vtag_q <= vtag_d;
      line_q <= line_d;
      rbuf_q <= rbuf_d;
      rvalid_q <= rvalid_d;
    end
endmodule

// File: tb/tb_dcache_s2_nway.sv
// tb_dcache_s2_nway: scenario tasks with a read-data scoreboard for dcache_s2_nway
module tb_dcache_s2_nway;
  localparam int WAYS = 4, LWD = 8, IW = 7, WW = 2, TW = 20;
  logic clk, rst_n, req_valid_i, req_wr_i, req_uc_i, mem_rend_i, mem_wend_i, cpu_ack_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0] req_wstrb_i;
  logic [WAYS*TW-1:0] tag_i;
  logic [WAYS-1:0] valid_i, dirty_i;
  logic [WAYS*32-1:0] data_i;
  logic [WW-1:0] victim_i;
  logic [LWD*32-1:0] victim_line_i, mem_rline_i;
  logic mem_rreq_o, mem_wreq_o, mem_uc_o, stall_o, hit_o, hit_we_o, fill_we_o, fill_dirty_o, cpu_rvalid_o;
  logic [31:0] mem_addr_o, hit_wdata_o, cpu_rdata_o;
  logic [LWD*32-1:0] mem_wline_o, fill_line_o;
  logic [3:0] mem_wstrb_o;
  logic [WW-1:0] hit_way_o, fill_way_o;
  int total, bad;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  dcache_s2_nway #(.WAYS(WAYS), .LINE_WORDS(LWD), .INDEX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_wr_i(req_wr_i), .req_uc_i(req_uc_i),
    .req_addr_i(req_addr_i), .req_wstrb_i(req_wstrb_i), .req_wdata_i(req_wdata_i), .tag_i(tag_i),
    .valid_i(valid_i), .dirty_i(dirty_i), .data_i(data_i), .victim_i(victim_i), .victim_line_i(victim_line_i),
    .mem_rreq_o(mem_rreq_o), .mem_wreq_o(mem_wreq_o), .mem_uc_o(mem_uc_o), .mem_addr_o(mem_addr_o),
    .mem_wline_o(mem_wline_o), .mem_wstrb_o(mem_wstrb_o), .mem_rend_i(mem_rend_i), .mem_wend_i(mem_wend_i),
    .mem_rline_i(mem_rline_i), .stall_o(stall_o), .hit_o(hit_o), .hit_way_o(hit_way_o), .hit_we_o(hit_we_o),
    .hit_wdata_o(hit_wdata_o), .fill_we_o(fill_we_o), .fill_way_o(fill_way_o), .fill_line_o(fill_line_o),
    .fill_dirty_o(fill_dirty_o), .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_ack_i(cpu_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    req_valid_i = 0; req_wr_i = 0; req_uc_i = 0; req_addr_i = 0; req_wstrb_i = 0; req_wdata_i = 0;
    tag_i = 0; valid_i = 0; dirty_i = 0; data_i = 0; victim_i = 0; victim_line_i = 0;
    mem_rend_i = 0; mem_wend_i = 0; mem_rline_i = 0; cpu_ack_i = 0;
  endtask

  task automatic set_way(input int w, input logic [TW-1:0] t, input logic v, input logic d, input logic [31:0] dat);
    tag_i[w*TW +: TW] = t; valid_i[w] = v; dirty_i[w] = d; data_i[w*32 +: 32] = dat;
  endtask

  task automatic test_reset();
    clr(); rst_n = 0;
    #2;
    total++; if ({stall_o, hit_o, hit_we_o, cpu_rvalid_o, mem_rreq_o, mem_wreq_o, mem_uc_o, fill_we_o, fill_dirty_o} !== 9'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0", {stall_o, hit_o, hit_we_o, cpu_rvalid_o, mem_rreq_o, mem_wreq_o, mem_uc_o, fill_we_o, fill_dirty_o}); end
    total++; if ((mem_addr_o | cpu_rdata_o | hit_wdata_o | mem_wline_o[31:0] | fill_line_o[31:0]) !== 32'h0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", mem_addr_o, cpu_rdata_o); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_load_hit();
    @(negedge clk); clr();
    req_valid_i = 1; req_addr_i = 32'h0000_2048; cpu_ack_i = 1;
    set_way(0, 20'h3, 1, 0, 32'h0123_4567); set_way(1, 20'h2, 1, 0, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    total++; if (hit_o !== 1'b1 || hit_way_o !== 2'd1) begin bad++; $display("FAIL ld_hit_way got=%b/%0d exp=1/1", hit_o, hit_way_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL ld_hit_stall got=%b exp=0", stall_o); end
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    total++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== e) begin bad++; $display("FAIL ld_hit_data got=%b/%h exp=1/%h", cpu_rvalid_o, cpu_rdata_o, e); end
    @(negedge clk); clr(); #1;
    total++; if (cpu_rvalid_o !== 1'b0) begin bad++; $display("FAIL ld_hit_acked got=%b exp=0", cpu_rvalid_o); end
  endtask

  task automatic test_store_hit();
    @(negedge clk); clr();
    req_valid_i = 1; req_wr_i = 1; req_addr_i = 32'h0000_5000; req_wstrb_i = 4'b0101; req_wdata_i = 32'h1122_3344;
    set_way(0, 20'h5, 1, 0, 32'hAABB_CCDD);
    #1;
    total++; if (hit_we_o !== 1'b1 || hit_way_o !== 2'd0) begin bad++; $display("FAIL st_hit_we got=%b/%0d exp=1/0", hit_we_o, hit_way_o); end
    total++; if (hit_wdata_o !== 32'hAA22_CC44) begin bad++; $display("FAIL st_hit_wdata got=%h exp=AA22CC44", hit_wdata_o); end
    total++; if (stall_o !== 1'b0 || cpu_rvalid_o !== 1'b0) begin bad++; $display("FAIL st_hit_side got=%b/%b exp=0/0", stall_o, cpu_rvalid_o); end
  endtask

  task automatic test_load_miss();
    int n; logic [31:0] a;
    @(negedge clk); clr();
    req_valid_i = 1; req_addr_i = 32'h0000_1024;
    #1;
    total++; if (stall_o !== 1'b1 || hit_o !== 1'b0) begin bad++; $display("FAIL ld_miss_stall got=%b/%b exp=1/0", stall_o, hit_o); end
    @(negedge clk); clr(); n = 0; a = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_rreq_o) begin n++; a = mem_addr_o; end
      if (mem_wreq_o) n += 10;
      @(negedge clk);
    end
    total++; if (n !== 1 || a !== 32'h0000_1020) begin bad++; $display("FAIL ld_miss_rreq got=%0d@%h exp=1@00001020", n, a); end
    mem_rend_i = 1;
    for (int k = 0; k < LWD; k++) mem_rline_i[k*32 +: 32] = 32'h1000_0000 + k;
    exp_q.push_back(32'h1000_0001);
    @(negedge clk); clr(); #1;
    total++; if (fill_we_o !== 1'b1 || fill_way_o !== 2'd0 || fill_dirty_o !== 1'b0 || stall_o !== 1'b1) begin bad++; $display("FAIL ld_miss_fill got=%b%0d%b%b exp=1001", fill_we_o, fill_way_o, fill_dirty_o, stall_o); end
    total++; if (fill_line_o[63:32] !== 32'h1000_0001) begin bad++; $display("FAIL ld_miss_line got=%h exp=10000001", fill_line_o[63:32]); end
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    total++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== e) begin bad++; $display("FAIL ld_miss_data got=%b/%h exp=1/%h", cpu_rvalid_o, cpu_rdata_o, e); end
    @(negedge clk); #1;
    total++; if (stall_o !== 1'b0 || fill_we_o !== 1'b0 || cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 32'h1000_0001) begin bad++; $display("FAIL ld_miss_hold got=%b%b%b/%h exp=001/10000001", stall_o, fill_we_o, cpu_rvalid_o, cpu_rdata_o); end
    cpu_ack_i = 1;
    @(negedge clk); cpu_ack_i = 0; #1;
    total++; if (cpu_rvalid_o !== 1'b0) begin bad++; $display("FAIL ld_miss_ack got=%b exp=0", cpu_rvalid_o); end
  endtask

  task automatic test_dirty_store_miss();
    int n, m; logic [31:0] a; logic [LWD*32-1:0] vl, wl;
    @(negedge clk); clr();
    req_valid_i = 1; req_wr_i = 1; req_addr_i = 32'h0001_2074; req_wstrb_i = 4'b0011; req_wdata_i = 32'hCAFE_1234;
    set_way(2, 20'h55, 1, 1, 32'h0); victim_i = 2;
    for (int k = 0; k < LWD; k++) vl[k*32 +: 32] = 32'hB000_0000 + k;
    victim_line_i = vl;
    #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL st_miss_stall got=%b exp=1", stall_o); end
    @(negedge clk); clr(); victim_i = 1; victim_line_i = '1; n = 0; m = 0; a = 0; wl = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_wreq_o) begin n++; a = mem_addr_o; wl = mem_wline_o; end
      if (mem_rreq_o) m++;
      @(negedge clk);
    end
    total++; if (n !== 1 || m !== 0 || a !== 32'h0005_5060) begin bad++; $display("FAIL wb_req got=%0d/%0d@%h exp=1/0@00055060", n, m, a); end
    total++; if (wl !== vl) begin bad++; $display("FAIL wb_line got=%h exp=%h", wl[63:0], vl[63:0]); end
    mem_wend_i = 1;
    @(negedge clk); mem_wend_i = 0; n = 0; a = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_rreq_o) begin n++; a = mem_addr_o; end
      @(negedge clk);
    end
    total++; if (n !== 1 || a !== 32'h0001_2060) begin bad++; $display("FAIL st_rf_req got=%0d@%h exp=1@00012060", n, a); end
    mem_rend_i = 1;
    for (int k = 0; k < LWD; k++) mem_rline_i[k*32 +: 32] = 32'hA000_0000 + k;
    @(negedge clk); clr(); #1;
    total++; if (fill_we_o !== 1'b1 || fill_way_o !== 2'd2 || fill_dirty_o !== 1'b1) begin bad++; $display("FAIL st_fill got=%b/%0d/%b exp=1/2/1", fill_we_o, fill_way_o, fill_dirty_o); end
    total++; if (fill_line_o[5*32 +: 32] !== 32'hA000_1234 || fill_line_o[4*32 +: 32] !== 32'hA000_0004) begin bad++; $display("FAIL st_fill_merge got=%h/%h exp=A0001234/A0000004", fill_line_o[5*32 +: 32], fill_line_o[4*32 +: 32]); end
    total++; if (cpu_rvalid_o !== 1'b0) begin bad++; $display("FAIL st_fill_rvalid got=%b exp=0", cpu_rvalid_o); end
    @(negedge clk); #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL st_miss_done got=%b exp=0", stall_o); end
  endtask

  task automatic test_uc_store();
    int n; logic u; logic [3:0] s; logic [31:0] a, w;
    @(negedge clk); clr();
    req_valid_i = 1; req_uc_i = 1; req_wr_i = 1; req_addr_i = 32'h4000_0010; req_wstrb_i = 4'b1000; req_wdata_i = 32'h9900_0000;
    #1;
    total++; if (stall_o !== 1'b1 || hit_o !== 1'b0) begin bad++; $display("FAIL uc_stall got=%b/%b exp=1/0", stall_o, hit_o); end
    @(negedge clk); clr(); n = 0; u = 0; s = 0; a = 0; w = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_wreq_o) begin n++; u = mem_uc_o; s = mem_wstrb_o; a = mem_addr_o; w = mem_wline_o[31:0]; end
      if (mem_rreq_o) n += 10;
      @(negedge clk);
    end
    total++; if (n !== 1 || u !== 1'b1 || s !== 4'b1000) begin bad++; $display("FAIL uc_wreq got=%0d/%b/%b exp=1/1/1000", n, u, s); end
    total++; if (a !== 32'h4000_0010 || w !== 32'h9900_0000) begin bad++; $display("FAIL uc_waddr got=%h/%h exp=40000010/99000000", a, w); end
    mem_rend_i = 1; mem_rline_i = '1;
    @(negedge clk); clr(); #1;
    total++; if (stall_o !== 1'b1 || cpu_rvalid_o !== 1'b0) begin bad++; $display("FAIL uc_spurious got=%b/%b exp=1/0", stall_o, cpu_rvalid_o); end
    mem_wend_i = 1;
    @(negedge clk); clr(); #1;
    total++; if (stall_o !== 1'b0 || mem_uc_o !== 1'b0) begin bad++; $display("FAIL uc_done got=%b/%b exp=0/0", stall_o, mem_uc_o); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk); clr();
    req_valid_i = 1; req_addr_i = 32'h0000_3000;
    @(negedge clk); clr();
    @(negedge clk); #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL rst_mid_busy got=%b exp=1", stall_o); end
    rst_n = 0; #1;
    total++; if ({stall_o, mem_rreq_o, mem_wreq_o, fill_we_o, cpu_rvalid_o} !== 5'b0 || mem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_mid_out got=%b/%h exp=0/0", {stall_o, mem_rreq_o, mem_wreq_o, fill_we_o, cpu_rvalid_o}, mem_addr_o); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    req_valid_i = 1; req_addr_i = 32'h0000_7ABC; cpu_ack_i = 1; set_way(3, 20'h7, 1, 0, 32'h5A5A_1234);
    exp_q.push_back(32'h5A5A_1234);
    #1;
    total++; if (hit_o !== 1'b1 || hit_way_o !== 2'd3 || stall_o !== 1'b0) begin bad++; $display("FAIL rst_mid_hit got=%b/%0d/%b exp=1/3/0", hit_o, hit_way_o, stall_o); end
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    total++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== e) begin bad++; $display("FAIL rst_mid_data got=%b/%h exp=1/%h", cpu_rvalid_o, cpu_rdata_o, e); end
    @(negedge clk); clr(); n = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_rreq_o || fill_we_o) n++;
      @(negedge clk);
    end
    total++; if (n !== 0) begin bad++; $display("FAIL rst_mid_nopulse got=%0d exp=0", n); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); clr();
    req_valid_i = 1; req_addr_i = 32'h0000_9000; set_way(0, 20'h9, 1, 0, 32'h1111_1111);
    exp_q.push_back(32'h1111_1111);
    #1;
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    total++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== e || stall_o !== 1'b0) begin bad++; $display("FAIL b2b_first got=%b/%h/%b exp=1/%h/0", cpu_rvalid_o, cpu_rdata_o, stall_o, e); end
    @(negedge clk);
    req_addr_i = 32'h0000_9004; data_i[31:0] = 32'h2222_2222; #1;
    total++; if (stall_o !== 1'b1 || cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 32'h1111_1111) begin bad++; $display("FAIL b2b_hold got=%b/%b/%h exp=1/1/11111111", stall_o, cpu_rvalid_o, cpu_rdata_o); end
    cpu_ack_i = 1;
    @(negedge clk);
    exp_q.push_back(32'h2222_2222);
    #1;
    e = exp_q.size() ? exp_q.pop_front() : 32'hx;
    total++; if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== e || stall_o !== 1'b0) begin bad++; $display("FAIL b2b_second got=%b/%h/%b exp=1/%h/0", cpu_rvalid_o, cpu_rdata_o, stall_o, e); end
    @(negedge clk); clr(); #1;
    total++; if (cpu_rvalid_o !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", cpu_rvalid_o); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_load_hit();
    test_store_hit();
    test_load_miss();
    test_dirty_store_miss();
    test_uc_store();
    test_reset_mid();
    test_back_to_back();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
